// File: rtl/dma_rd_streamer.sv
// Read-side DMA streamer: splits a (src addr, byte count) descriptor into 4 KB-safe AXI AR
// bursts, bounds outstanding bursts, and reports completion plus the first burst error.
module dma_rd_streamer #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned LEN_W           = 32,
    parameter int unsigned DATA_BYTES      = 8,
    parameter int unsigned MAX_BEATS       = 256,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stream_valid_i,
    input  logic [ADDR_W-1:0] desc_src_addr_i,
    input  logic [LEN_W-1:0]  desc_num_bytes_i,
    output logic              stream_done_o,
    output logic              err_valid_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    output logic [ADDR_W-1:0] ar_addr_o,
    output logic [7:0]        ar_len_o,
    output logic [2:0]        ar_size_o,
    input  logic              rsp_valid_i,
    input  logic              rsp_err_i
);
    localparam int unsigned LOG_DB = $clog2(DATA_BYTES);
    localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              ar_valid_q, ar_valid_d;
    logic              err_seen_q, err_seen_d;
    logic              err_valid_q, err_valid_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] fifo_mem [MAX_OUTSTANDING];

    logic [12:0]       to_4k_bytes;
    logic [LEN_W-1:0]  beats_4k, beats_rem, beats, burst_bytes;
    logic              hs, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Burst size: bounded by MAX_BEATS, what is left, and the distance to the next 4 KB page.
    always_comb begin
        to_4k_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
        beats_4k    = LEN_W'(to_4k_bytes >> LOG_DB);
        beats_rem   = rem_q >> LOG_DB;
        beats       = LEN_W'(MAX_BEATS);
        if (beats_rem < beats) beats = beats_rem;
        if (beats_4k < beats)  beats = beats_4k;
        burst_bytes = beats << LOG_DB;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        ar_valid_d  = ar_valid_q;
        err_seen_d  = err_seen_q;
        err_valid_d = 1'b0;
        err_addr_d  = err_addr_q;
        done_d      = 1'b0;

        hs       = ar_valid_q && ar_ready_i;
        pop      = rsp_valid_i && (cnt_q != '0);
        cnt_d    = cnt_q + CNT_W'(hs) - CNT_W'(pop);
        wr_ptr_d = hs  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        if (pop && rsp_err_i && !err_seen_q) begin
            err_valid_d = 1'b1;
            err_addr_d  = fifo_mem[rd_ptr_q];
            err_seen_d  = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (stream_valid_i) begin
                    addr_d     = desc_src_addr_i;
                    rem_d      = desc_num_bytes_i;
                    err_seen_d = 1'b0;
                    if (desc_num_bytes_i == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (((desc_src_addr_i & ADDR_W'(DATA_BYTES - 1)) != '0) ||
                                 ((desc_num_bytes_i & LEN_W'(DATA_BYTES - 1)) != '0)) begin
                        err_valid_d = 1'b1;
                        err_addr_d  = desc_src_addr_i;
                        err_seen_d  = 1'b1;
                        state_d     = DONE;
                        done_d      = 1'b1;
                    end else begin
                        state_d    = REQ;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (hs) begin
                    addr_d = addr_q + ADDR_W'(burst_bytes);
                    rem_d  = rem_q - burst_bytes;
                end
                // A request already on the bus is held until accepted, even after an error.
                if (ar_valid_q && !ar_ready_i) begin
                    ar_valid_d = 1'b1;
                end else if ((rem_d == '0) || err_seen_d) begin
                    ar_valid_d = 1'b0;
                    state_d    = DRAIN;
                end else begin
                    ar_valid_d = (cnt_d < CNT_W'(MAX_OUTSTANDING));
                end
            end
            DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (!stream_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ar_valid_q  <= 1'b0;
            err_seen_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ar_valid_q  <= ar_valid_d;
            err_seen_q  <= err_seen_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) fifo_mem[wr_ptr_q] <= addr_q;
    end

    assign stream_done_o = done_q;
    assign err_valid_o   = err_valid_q;
    assign err_addr_o    = err_addr_q;
    assign ar_valid_o    = ar_valid_q;
    assign ar_addr_o     = ar_valid_q ? addr_q : '0;
    assign ar_len_o      = ar_valid_q ? 8'(beats - 1'b1) : '0;
    assign ar_size_o     = 3'(LOG_DB);

endmodule

// File: tb/tb_dma_rd_streamer.sv
// Scoreboard bench for dma_rd_streamer: stimulus pushes expected AR/err/done events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_dma_rd_streamer;
    logic        clk = 1'b0;
    logic        rst;
    logic        stream_valid_i;
    logic [31:0] desc_src_addr_i;
    logic [31:0] desc_num_bytes_i;
    logic        stream_done_o;
    logic        err_valid_o;
    logic [31:0] err_addr_o;
    logic        ar_valid_o;
    logic        ar_ready_i;
    logic [31:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic        rsp_valid_i;
    logic        rsp_err_i;

    dma_rd_streamer #(
        .ADDR_W(32), .LEN_W(32), .DATA_BYTES(8), .MAX_BEATS(256), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst(rst),
        .stream_valid_i(stream_valid_i), .desc_src_addr_i(desc_src_addr_i),
        .desc_num_bytes_i(desc_num_bytes_i), .stream_done_o(stream_done_o),
        .err_valid_o(err_valid_o), .err_addr_o(err_addr_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
        .rsp_valid_i(rsp_valid_i), .rsp_err_i(rsp_err_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t         exp_ar[$];
    logic [31:0] exp_err[$];
    int          exp_done  = 0;
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          ar_seen   = 0;
    int          err_seen  = 0;
    int          done_cyc  = 0;
    int          rsp_cyc   = 0;
    logic        hold_prev = 1'b0;
    logic [39:0] hold_val;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT-presented event against the scoreboard queues.
    always @(negedge clk) begin
        ar_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                chk("ar_stable", {ar_valid_o, ar_addr_o, ar_len_o}, {1'b1, hold_val});
            if (ar_valid_o && ar_ready_i) begin
                ar_seen++;
                if (exp_ar.size() == 0) begin
                    chk("ar_unexpected", {ar_addr_o, ar_len_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_ar.pop_front();
                    chk("ar_addr", ar_addr_o, e.addr);
                    chk("ar_len", ar_len_o, e.len);
                    chk("ar_size", ar_size_o, 3);
                end
            end
            hold_prev = ar_valid_o && !ar_ready_i;
            hold_val  = {ar_addr_o, ar_len_o};
            if (err_valid_o) begin
                err_seen++;
                if (exp_err.size() == 0) chk("err_unexpected", err_addr_o, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("err_addr", err_addr_o, exp_err.pop_front());
            end
            if (stream_done_o) begin
                done_cyc = cyc;
                chk("done_expected", exp_done > 0, 1);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t e;
        e.addr = a;
        e.len  = l;
        exp_ar.push_back(e);
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] n);
        exp_done         = 1;
        stream_valid_i   = 1'b1;
        desc_src_addr_i  = a;
        desc_num_bytes_i = n;
    endtask

    task automatic wait_ar(input int n);
        int t = 0;
        while (ar_seen < n && t < 300) begin
            tick(1);
            t++;
        end
        chk("wait_ar_reached", ar_seen >= n, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_done > 0 && t < 300) begin
            tick(1);
            t++;
        end
        chk("wait_done_reached", exp_done, 0);
    endtask

    task automatic rsp(input logic err);
        rsp_valid_i = 1'b1;
        rsp_err_i   = err;
        rsp_cyc     = cyc;
        tick(1);
        rsp_valid_i = 1'b0;
        rsp_err_i   = 1'b0;
    endtask

    // Valid stays high a few cycles past done to catch re-triggering off stale valid.
    task automatic finish_desc(input string tag);
        tick(3);
        stream_valid_i = 1'b0;
        tick(2);
        chk({tag, "_ar_drained"}, exp_ar.size(), 0);
        chk({tag, "_err_drained"}, exp_err.size(), 0);
    endtask

    initial begin
        int base;
        int t;
        rst = 1'b1;
        stream_valid_i = 1'b0; desc_src_addr_i = '0; desc_num_bytes_i = '0;
        ar_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_err_i = 1'b0;
        tick(3);
        chk("reset_ctrl", {ar_valid_o, stream_done_o, err_valid_o}, 0);
        chk("reset_ar_addr", ar_addr_o, 0);
        chk("reset_ar_len", ar_len_o, 0);
        chk("reset_err_addr", err_addr_o, 0);
        chk("reset_ar_size", ar_size_o, 3);
        rst = 1'b0;
        tick(2);

        // 1: single burst, done one cycle after the response
        ar_ready_i = 1'b1;
        push_ar(32'h1000, 8'd7);
        start(32'h1000, 64);
        wait_ar(ar_seen + 1);
        rsp(1'b0);
        wait_done();
        chk("t1_done_latency", done_cyc - rsp_cyc, 1);
        finish_desc("t1");

        // 2: 4 KB split with ready held low at first
        ar_ready_i = 1'b0;
        base = ar_seen;
        push_ar(32'h0FF0, 8'd1);
        push_ar(32'h1000, 8'd3);
        start(32'h0FF0, 48);
        tick(4);
        ar_ready_i = 1'b1;
        wait_ar(base + 2);
        rsp(1'b0);
        rsp(1'b0);
        wait_done();
        finish_desc("t2");

        // 3: outstanding limit holds off the third burst
        base = ar_seen;
        push_ar(32'h0000, 8'd255);
        push_ar(32'h0800, 8'd255);
        push_ar(32'h1000, 8'd255);
        start(32'h0, 6144);
        wait_ar(base + 2);
        tick(10);
        chk("t3_held_valid", ar_valid_o, 0);
        chk("t3_held_count", ar_seen - base, 2);
        rsp(1'b0);
        wait_ar(base + 3);
        rsp(1'b0);
        rsp(1'b0);
        wait_done();
        finish_desc("t3");

        // 4: first response errors, second error suppressed
        base = err_seen;
        push_ar(32'h0000, 8'd255);
        push_ar(32'h0800, 8'd255);
        exp_err.push_back(32'h0);
        start(32'h0, 4096);
        wait_ar(ar_seen + 2);
        rsp(1'b1);
        rsp(1'b1);
        wait_done();
        chk("t4_err_count", err_seen - base, 1);
        finish_desc("t4");

        // 4b: error while throttled stops further bursts
        base = ar_seen;
        push_ar(32'h0000, 8'd255);
        push_ar(32'h0800, 8'd255);
        exp_err.push_back(32'h0);
        start(32'h0, 8192);
        wait_ar(base + 2);
        tick(3);
        rsp(1'b1);
        tick(6);
        chk("t4b_no_more_ar", ar_seen - base, 2);
        rsp(1'b0);
        wait_done();
        finish_desc("t4b");

        // 5: misaligned address, then zero length
        base = ar_seen;
        exp_err.push_back(32'h1004);
        start(32'h1004, 64);
        wait_done();
        finish_desc("t5a");
        t = err_seen;
        start(32'h2000, 0);
        wait_done();
        finish_desc("t5b");
        chk("t5_no_ar", ar_seen - base, 0);
        chk("t5b_no_err", err_seen - t, 0);

        // 6: reset while a request is pending on the bus
        ar_ready_i = 1'b0;
        start(32'h0, 6144);
        exp_done = 0;
        t = 0;
        while (!ar_valid_o && t < 20) begin
            tick(1);
            t++;
        end
        chk("t6_ar_pending", ar_valid_o, 1);
        rst = 1'b1;
        stream_valid_i = 1'b0;
        tick(1);
        chk("t6_rst_ctrl", {ar_valid_o, stream_done_o, err_valid_o}, 0);
        chk("t6_rst_ar_addr", ar_addr_o, 0);
        chk("t6_rst_ar_len", ar_len_o, 0);
        rst = 1'b0;
        ar_ready_i = 1'b1;
        tick(1);
        rsp(1'b1);
        tick(5);
        chk("t6_idle_after_rsp", {ar_valid_o, stream_done_o, err_valid_o}, 0);
        chk("t6_ar_drained", exp_ar.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
